// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline latches.
// Drives per-latch enables/flushes, latches halt, counts stall cycles.
module pipeline_hazard_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        em_dREN,
  input  logic        em_dWEN,
  input  logic        de_dREN,
  input  logic [4:0]  de_wsel,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic        fd_uses_rt,
  input  logic        br_taken,
  input  logic        mw_halt,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_en,
  output logic        em_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t state, next_state;
  logic   mem_wait;
  logic   load_use;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // Once in MEM_WAIT, only dhit releases the wait.
  always_comb begin
    mem_wait = 1'b0;
    if (state == MEM_WAIT) mem_wait = !dhit;
    else mem_wait = (em_dREN | em_dWEN) & !dhit;
  end

  always_comb begin
    load_use = de_dREN && (de_wsel != 5'd0) &&
               ((de_wsel == fd_rs) ||
                (fd_uses_rt && (de_wsel == fd_rt)));
  end

  always_comb begin
    next_state = state;
    pc_en      = 1'b0;
    fd_en      = 1'b0;
    de_en      = 1'b0;
    em_en      = 1'b0;
    mw_en      = 1'b0;
    fd_flush   = 1'b0;
    de_flush   = 1'b0;
    em_flush   = 1'b0;
    if (!nRST) begin
      next_state = RUN;
    end else if (state == HALTED) begin
      next_state = HALTED;
    end else if (mem_wait) begin
      next_state = MEM_WAIT;
    end else begin
      mw_en = 1'b1;
      if (br_taken) begin
        pc_en    = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        em_flush = 1'b1;
      end else if (load_use) begin
        de_flush = 1'b1;
        em_en    = 1'b1;
      end else if (!ihit) begin
        fd_flush = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
      end else begin
        pc_en = 1'b1;
        fd_en = 1'b1;
        de_en = 1'b1;
        em_en = 1'b1;
      end
      next_state = (mw_halt && mw_en) ? HALTED : RUN;
    end
  end

  assign halted = (state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= 16'd0;
    end else if ((state != HALTED) && !pc_en &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Priority-rule reference model, directed plan plus random traffic.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, em_dREN, em_dWEN, de_dREN;
  logic [4:0]  de_wsel, fd_rs, fd_rt;
  logic        fd_uses_rt, br_taken, mw_halt;
  logic        pc_en, fd_en, de_en, em_en, mw_en;
  logic        fd_flush, de_flush, em_flush;
  logic        halted;
  logic [15:0] stall_cnt;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit), .dhit(dhit),
    .em_dREN(em_dREN), .em_dWEN(em_dWEN),
    .de_dREN(de_dREN), .de_wsel(de_wsel),
    .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rt(fd_uses_rt),
    .br_taken(br_taken), .mw_halt(mw_halt),
    .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en),
    .em_en(em_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .de_flush(de_flush),
    .em_flush(em_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  strb;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: halted flag, "waiting on data" flag, stall count.
  bit m_halted = 0;
  bit m_wait   = 0;
  int m_cnt    = 0;

  task automatic set_in(input bit ih, input bit dh,
                        input bit er, input bit ew,
                        input bit dr, input int ws,
                        input int rs, input int rt,
                        input bit urt, input bit br,
                        input bit hl);
    ihit = ih; dhit = dh; em_dREN = er; em_dWEN = ew;
    de_dREN = dr; de_wsel = 5'(ws);
    fd_rs = 5'(rs); fd_rt = 5'(rt);
    fd_uses_rt = urt; br_taken = br; mw_halt = hl;
  endtask

  task automatic rand_in();
    ihit       = ($urandom_range(0, 3) != 0);
    dhit       = ($urandom_range(0, 1) != 0);
    em_dREN    = ($urandom_range(0, 3) == 0);
    em_dWEN    = ($urandom_range(0, 5) == 0);
    de_dREN    = ($urandom_range(0, 2) == 0);
    de_wsel    = 5'($urandom_range(0, 3));
    fd_rs      = 5'($urandom_range(0, 3));
    fd_rt      = 5'($urandom_range(0, 3));
    fd_uses_rt = ($urandom_range(0, 1) != 0);
    br_taken   = ($urandom_range(0, 5) == 0);
    mw_halt    = ($urandom_range(0, 60) == 0);
  endtask

  // One cycle: inputs already applied just after an edge.
  task automatic step(input bit rst);
    exp_t e;
    bit   mw, lu;
    bit [7:0] s;
    bit   nh, nw;
    int   nc;
    nRST = !rst;
    s = 8'h00;
    if (rst) begin
      m_halted = 0; m_wait = 0; m_cnt = 0;
      nh = 0; nw = 0; nc = 0;
    end else begin
      mw = m_wait ? !dhit : ((em_dREN || em_dWEN) && !dhit);
      lu = de_dREN && (de_wsel != 0) &&
           ((de_wsel == fd_rs) ||
            (fd_uses_rt && (de_wsel == fd_rt)));
      // {pc,fd,de,em,mw,fd_fl,de_fl,em_fl}
      if (m_halted)      s = 8'b0000_0000;
      else if (mw)       s = 8'b0000_0000;
      else if (br_taken) s = 8'b1000_1111;
      else if (lu)       s = 8'b0001_1010;
      else if (!ihit)    s = 8'b0011_1100;
      else               s = 8'b1111_1000;
      nh = m_halted || (!mw && mw_halt);
      nw = !m_halted && mw;
      nc = m_cnt;
      if (!m_halted && !s[7] && m_cnt < 65535) nc = m_cnt + 1;
    end
    e.strb = s;
    e.hlt  = m_halted;
    e.cnt  = 16'(m_cnt);
    q.push_back(e);
    @(posedge CLK);
    m_halted = nh; m_wait = nw; m_cnt = nc;
    #1;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    logic [7:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {pc_en, fd_en, de_en, em_en, mw_en,
             fd_flush, de_flush, em_flush};
      n_tests++;
      if (got !== e.strb) begin
        n_fail++;
        $display("FAIL strobes t=%0t got %b exp %b",
                 $time, got, e.strb);
      end
      n_tests++;
      if (halted !== e.hlt) begin
        n_fail++;
        $display("FAIL halted t=%0t got %b exp %b",
                 $time, halted, e.hlt);
      end
      n_tests++;
      if (stall_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL stall_cnt t=%0t got %0d exp %0d",
                 $time, stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    nRST = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    step(1);
    step(1);
    // normal flow
    repeat (10) step(0);
    // load-use, then reg0 non-hazard
    set_in(1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0);
    step(0);
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0);
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0);
    set_in(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    step(0);
    set_in(1, 0, 0, 0, 1, 7, 1, 7, 1, 0, 0);
    step(0);
    // memory wait with pending branch
    step(1);
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step(0);
    set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0);
    // branch wins over load-use and fetch wait
    set_in(0, 0, 0, 0, 1, 3, 3, 3, 1, 1, 0);
    step(0);
    // halt, then inputs ignored, then reset mid-halt
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0);
    set_in(0, 0, 1, 0, 1, 2, 2, 2, 1, 1, 0);
    repeat (4) step(0);
    step(1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      if (m_halted) step($urandom_range(0, 4) == 0);
      else step($urandom_range(0, 150) == 0);
    end
    // saturation
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) step(0);
    step(0);
    repeat (3) @(posedge CLK);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain got %0d left exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush controller for the five-stage pipeline. It sits beside the FD/DE/EM/MW pipeline latches and drives their per-latch enable and flush strobes from cache handshakes, a load-use check and branch resolution. It also latches processor halt and counts stall cycles. It is the consumer side of the latch contents: it reads fields out of the latch outputs and decides whether the next `*_in` values may be captured.

## Interface
- No parameters.
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction fetch for the current PC completes this cycle.
- `dhit`  in  1  data access held in EM completes this cycle.
- `em_dREN`, `em_dWEN`  in  1 each  EM latch holds a load or store (`EM_out.dcuREN` / `EM_out.dcuWEN`).
- `de_dREN`  in  1  DE latch holds a load (`DE_out.dcuREN`).
- `de_wsel`  in  5  destination register of the load in DE.
- `fd_rs`, `fd_rt`  in  5 each  source registers of the instruction in FD.
- `fd_uses_rt`  in  1  FD instruction reads `rt` as a source.
- `br_taken`  in  1  branch/jump in EM resolved as redirecting PC.
- `mw_halt`  in  1  MW latch holds a halt instruction.
- `pc_en`  out  1  PC register may load its next value.
- `fd_en`, `de_en`, `em_en`, `mw_en`  out  1 each  latch captures its `_in`.
- `fd_flush`, `de_flush`, `em_flush`  out  1 each  latch loads all-zero (bubble); overrides `_en`.
- `halted`  out  1  processor halted.
- `stall_cnt`  out  16  cycles with `pc_en`=0 since reset.

## Operation
- FSM states: RUN, MEM_WAIT, HALTED. Reset state is RUN.
- Output condition priority per cycle, highest first: HALTED, memory wait, branch, load-use, fetch wait, normal.
- **HALTED**
  - All `_en`, `_flush` and `pc_en` are 0. `halted`=1.
  - Leaves only via `nRST`.
- **Memory wait**
  - Condition: (`em_dREN`|`em_dWEN`) & !`dhit`.
  - All `_en` and `pc_en` are 0. No flushes.
  - In RUN, this condition moves the FSM to MEM_WAIT.
  - MEM_WAIT stays while !`dhit`. On `dhit`, the same cycle is evaluated by the lower-priority rules and the FSM returns to RUN.
- **Branch**
  - Condition: `br_taken` and not memory-waiting.
  - `pc_en`=1 regardless of `ihit`.
  - `fd_flush`=`de_flush`=`em_flush`=1. `mw_en`=1.
  - A `br_taken` seen during MEM_WAIT is acted on in the `dhit` cycle.
- **Load-use**
  - Condition: `de_dREN` & `de_wsel`!=0 & (`de_wsel`==`fd_rs` | (`fd_uses_rt` & `de_wsel`==`fd_rt`)).
  - `pc_en`=0, `fd_en`=0 (hold), `de_flush`=1, `em_en`=`mw_en`=1.
- **Fetch wait**
  - Condition: !`ihit`.
  - `pc_en`=0, `fd_flush`=1, `de_en`=`em_en`=`mw_en`=1.
- **Normal**
  - All `_en` and `pc_en` are 1. All flushes 0.
- **Halt**
  - When `mw_halt` & `mw_en` at a rising edge (not memory-waiting), the FSM enters HALTED.
  - The halt instruction itself is the last one retired.
- `stall_cnt`
  - Increments at each edge where state != HALTED and `pc_en`=0.
  - Saturates at 16'hFFFF; no wrap.
- Register 0 is never a hazard source: `de_wsel`==0 never triggers load-use.

## Timing
- All strobe outputs are combinational from the current state and inputs, and are valid in the same cycle. Latches act on the next rising `CLK`.
- `halted` and `stall_cnt` are registered; they update one edge after the causing cycle.
- Load-use costs exactly one bubble. The next cycle re-evaluates with the load now in EM, so no further stall occurs from that load.
- Branch penalty is 3 flushed slots. Flushes last one cycle.
- Reset (`nRST`=0, asynchronous, including mid-MEM_WAIT or HALTED):
  - State becomes RUN; `halted`=0; `stall_cnt`=0.
  - All `_en`, `_flush` and `pc_en` are forced to 0 while `nRST`=0.
  - Normal evaluation resumes at the first edge after release.

## Test plan
- **Normal flow:** `ihit`=1, `dhit`=0, no memory ops, no hazards for 10 cycles -> all `_en`=1, flushes 0, `stall_cnt`=0.
- **Load-use:** `de_dREN`=1, `de_wsel`=5, `fd_rs`=5, `ihit`=1 -> for one cycle `pc_en`=0, `fd_en`=0, `de_flush`=1; next cycle normal; `stall_cnt`=1.
  - Repeat with `de_wsel`=0, `fd_rs`=0 -> no stall.
- **Memory wait then branch:** `em_dREN`=1, `dhit`=0 for 3 cycles with `br_taken`=1 -> all `_en`=0 and state MEM_WAIT for 3 cycles; on `dhit`=1 -> `pc_en`=1 and all three flushes=1 in that cycle; `stall_cnt`=3.
- **Simultaneous events:** `br_taken`=1 with a load-use match and `ihit`=0 -> branch response only (`pc_en`=1, three flushes); `stall_cnt` unchanged.
- **Halt:** `mw_halt`=1 with `mw_en`=1 -> `halted`=1 after the edge; all strobes 0 thereafter regardless of inputs; `stall_cnt` frozen.
  - Assert `nRST`=0 mid-halt -> `halted`=0, `stall_cnt`=0 immediately.
- **Saturation:** hold `ihit`=0 for 65540 cycles -> `stall_cnt`=16'hFFFF, no wrap.
